// File: rtl/scaler_v.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scaler_v : vertical downscaler; blends the stored previous line with the |
// |            current line by the fraction of the output line position.     |
// |            Build option SCALER_V_ROUND_EN selects round-half-up blending. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module scaler_v #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int PIXEL_STEP    = 128,
    parameter int COE_WIDTH     = 8,
    parameter int LINE_SIZE_MAX = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            v_scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);
    localparam int C_FB    = $clog2(PIXEL_STEP);
    localparam int C_POS_W = 12 + C_FB;
    localparam int C_SUM_W = C_POS_W + 17;
    localparam int C_AW    = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
    localparam int C_ACC_W = PIXEL_WIDTH + COE_WIDTH + 1;

    localparam logic [C_SUM_W-1:0] C_POS_MAX   = C_SUM_W'({C_POS_W{1'b1}});
    localparam logic [C_POS_W-1:0] C_FRAC_MASK = C_POS_W'((1 << C_FB) - 1);
    localparam logic [15:0]        C_STEP_MIN  = 16'(PIXEL_STEP);
    localparam logic [12:0]        C_X_MAX     = 13'(LINE_SIZE_MAX);
    localparam logic [C_ACC_W-1:0] C_ONE       = C_ACC_W'(1) << COE_WIDTH;
`ifdef SCALER_V_ROUND_EN
    localparam logic [C_ACC_W-1:0] C_RND       = C_ACC_W'(1) << (COE_WIDTH - 1);
`else
    localparam logic [C_ACC_W-1:0] C_RND       = '0;
`endif

    logic                   r_vs_d;
    logic [C_POS_W-1:0]     r_pos;
    logic [15:0]            r_step;
    logic [11:0]            r_n;
    logic [12:0]            r_x;
    logic                   r_armed;
    logic                   r_first;
    logic                   r_emit;

    logic                   w_vs_fall;
    logic                   w_vs_rise;
    logic [C_SUM_W-1:0]     w_sum;
    logic [C_POS_W-1:0]     w_pos_adv;
    logic [C_POS_W-1:0]     w_pos_line;
    logic [11:0]            w_n_line;
    logic [11:0]            w_pos_int;
    logic                   w_emit_new;
    logic                   w_emit_line;
    logic [12:0]            w_x_pix;
    logic                   w_pix_ok;
    logic [COE_WIDTH-1:0]   w_coe;
    logic [C_AW-1:0]        w_addr;

    // A line that starts while the previous one was emitting sees pos already advanced.
    always_comb begin
        w_vs_fall   = r_vs_d & ~vs_i;
        w_vs_rise   = ~r_vs_d & vs_i;
        w_sum       = C_SUM_W'(r_pos) + C_SUM_W'(r_step);
        w_pos_adv   = (w_sum > C_POS_MAX) ? C_POS_W'(C_POS_MAX) : w_sum[C_POS_W-1:0];
        w_pos_line  = (hs_i && r_emit) ? w_pos_adv : r_pos;
        w_n_line    = r_first ? r_n : r_n + 12'd1;
        w_pos_int   = 12'(w_pos_line >> C_FB);
        w_emit_new  = r_armed && ({1'b0, w_n_line} == ({1'b0, w_pos_int} + 13'd1));
        w_emit_line = hs_i ? w_emit_new : r_emit;
        w_x_pix     = hs_i ? 13'd0 : r_x;
        w_pix_ok    = de_i && (w_x_pix < C_X_MAX);
        w_coe       = COE_WIDTH'(w_pos_line & C_FRAC_MASK) << (COE_WIDTH - C_FB);
        w_addr      = w_x_pix[C_AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_d  <= 1'b0;
            r_pos   <= '0;
            r_step  <= C_STEP_MIN;
            r_n     <= '0;
            r_x     <= '0;
            r_armed <= 1'b0;
            r_first <= 1'b0;
            r_emit  <= 1'b0;
        end else begin
            r_vs_d <= vs_i;
            if (w_vs_fall) begin
                r_pos   <= '0;
                r_n     <= '0;
                r_x     <= '0;
                r_step  <= (v_scale_step < C_STEP_MIN) ? C_STEP_MIN : v_scale_step;
                r_armed <= 1'b1;
                r_first <= 1'b1;
                r_emit  <= 1'b0;
            end else begin
                if (hs_i) begin
                    r_pos   <= w_pos_line;
                    r_n     <= w_n_line;
                    r_first <= 1'b0;
                    r_emit  <= w_emit_new;
                end else if (w_vs_rise && r_emit) begin
                    r_pos  <= w_pos_adv;
                    r_emit <= 1'b0;
                end
                if (de_i) begin
                    r_x <= (w_x_pix < C_X_MAX) ? w_x_pix + 13'd1 : w_x_pix;
                end else if (hs_i) begin
                    r_x <= '0;
                end
            end
        end
    end

    // Line buffer holds the previous line; read returns old data when written.
    logic [PIXEL_WIDTH-1:0] mem [LINE_SIZE_MAX];
    logic [PIXEL_WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (w_pix_ok) begin
            r_prev      <= mem[w_addr];
            mem[w_addr] <= di_i;
        end
    end

    logic                   r_v1, r_v2;
    logic                   r_hs1, r_hs2;
    logic                   r_vs1, r_vs2;
    logic [PIXEL_WIDTH-1:0] r_di1;
    logic [COE_WIDTH-1:0]   r_coe1;
    logic [C_ACC_W-1:0]     r_acc2;
    logic [C_ACC_W-1:0]     w_acc;

    always_comb begin
        w_acc = C_ACC_W'(r_prev) * (C_ONE - C_ACC_W'(r_coe1))
              + C_ACC_W'(r_di1) * C_ACC_W'(r_coe1)
              + C_RND;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_hs1  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs1  <= 1'b0;
            r_vs2  <= 1'b0;
            r_di1  <= '0;
            r_coe1 <= '0;
            r_acc2 <= '0;
            do_o   <= '0;
            de_o   <= 1'b0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
        end else begin
            r_v1   <= w_pix_ok && w_emit_line && !w_vs_fall;
            r_hs1  <= hs_i && w_emit_new && !w_vs_fall;
            r_vs1  <= vs_i;
            r_di1  <= di_i;
            r_coe1 <= w_coe;
            r_v2   <= r_v1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_acc2 <= w_acc;
            de_o   <= r_v2;
            hs_o   <= r_hs2;
            vs_o   <= r_vs2;
            do_o   <= r_v2 ? PIXEL_WIDTH'(r_acc2 >> COE_WIDTH) : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scaler_v.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scaler_v : directed frames for scaler_v with hand-computed outputs.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_scaler_v;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] v_scale_step;
    logic [7:0]  di_i;
    logic        de_i;
    logic        hs_i;
    logic        vs_i;
    logic [7:0]  do_o;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    logic [7:0] out_q[$];
    int         out_cyc[$];
    int         in_cyc[$];

    scaler_v dut (
        .clk          (clk),
        .rst          (rst),
        .v_scale_step (v_scale_step),
        .di_i         (di_i),
        .de_i         (de_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .do_o         (do_o),
        .de_o         (de_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (de_o) begin
            out_q.push_back(do_o);
            out_cyc.push_back(cyc);
        end
        if (hs_o) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // 8x8 frame, pixel value = mult * line index; optional reset pulse at pixel 4 of rst_line.
    task automatic drive_frame(input int step, input int mult, input bit gap,
                               input int rst_line, input logic [7:0] lat_mask);
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
        hs_cnt = 0;
        @(negedge clk);
        v_scale_step = 16'(step);
        vs_i = 1'b1;
        hs_i = 1'b0;
        de_i = 1'b0;
        repeat (4) @(negedge clk);
        vs_i = 1'b0;
        repeat (2) @(negedge clk);
        for (int y = 0; y < 8; y++) begin
            for (int p = 0; p < 8; p++) begin
                if (y == rst_line && p == 4) begin
                    @(negedge clk);
                    hs_i = 1'b0;
                    de_i = 1'b0;
                    check("pre_rst_de", de_o, 1);
                    check("pre_rst_do", do_o, 32);
                    #2 rst = 1'b1;
                    #1;
                    check("rst_do", do_o, 0);
                    check("rst_de", de_o, 0);
                end
                @(negedge clk);
                rst  = 1'b0;
                hs_i = (p == 0);
                de_i = 1'b1;
                di_i = 8'(mult * y);
                if (lat_mask[y]) in_cyc.push_back(cyc);
                if (gap) begin
                    @(negedge clk);
                    hs_i = 1'b0;
                    de_i = 1'b0;
                end
            end
            @(negedge clk);
            hs_i = 1'b0;
            de_i = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        vs_i = 1'b1;
        repeat (2) @(negedge clk);
        check("vs_o_early", vs_o, 0);
        @(negedge clk);
        check("vs_o_delay3", vs_o, 1);
        repeat (6) @(negedge clk);
    endtask

    // vals holds one expected byte per emitted line, first line in the low byte.
    task automatic check_frame(input string tag, input int n_exp, input logic [63:0] vals,
                               input int hs_exp, input bit chk_lat);
        check({tag, "_count"}, out_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < out_q.size(); i++)
            check({tag, "_pix"}, out_q[i], vals[8*(i/8) +: 8]);
        check({tag, "_hs"}, hs_cnt, hs_exp);
        if (chk_lat) begin
            check({tag, "_lat_n"}, in_cyc.size(), out_cyc.size());
            for (int i = 0; i < in_cyc.size() && i < out_cyc.size(); i++)
                check({tag, "_lat"}, out_cyc[i] - in_cyc[i], 3);
        end
    endtask

    initial begin
        rst          = 1'b1;
        v_scale_step = 16'd128;
        di_i         = 8'd0;
        de_i         = 1'b0;
        hs_i         = 1'b0;
        vs_i         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_do", do_o, 0);
        check("reset_de", de_o, 0);
        check("reset_hs", hs_o, 0);
        check("reset_vs", vs_o, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("vs_follow", vs_o, 1);

        drive_frame(128, 1, 1'b0, -1, 8'h00);
        check_frame("s128", 56, 64'h0006050403020100, 7, 1'b0);

        drive_frame(256, 16, 1'b0, -1, 8'h00);
        check_frame("s256", 32, 64'h0000000060402000, 4, 1'b0);

        drive_frame(192, 1, 1'b0, -1, 8'h00);
`ifdef SCALER_V_ROUND_EN
        check_frame("s192", 40, 64'h0000000605030200, 5, 1'b0);
`else
        check_frame("s192", 40, 64'h0000000604030100, 5, 1'b0);
`endif

        drive_frame(256, 16, 1'b1, -1, 8'hAA);
        check_frame("gap", 32, 64'h0000000060402000, 4, 1'b1);

        drive_frame(256, 16, 1'b0, 3, 8'h00);
        check_frame("midrst", 10, 64'h0000000000002000, 2, 1'b0);

        drive_frame(256, 16, 1'b0, -1, 8'h00);
        check_frame("post_rst", 32, 64'h0000000060402000, 4, 1'b0);

        drive_frame(64, 1, 1'b0, -1, 8'h00);
        check_frame("s64", 56, 64'h0006050403020100, 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
